// File: rtl/fib_pkg.sv
// Shared types and default widths for the fib_acc Fibonacci accelerator.
package fib_pkg;

   typedef enum logic [1:0] {IDLE, CALC, DONE} fib_state_e;

   localparam int unsigned FIB_N_W    = 8;
   localparam int unsigned FIB_DATA_W = 32;

endpackage

// File: rtl/fib_ctrl.sv
// Control FSM for fib_acc: request/response handshakes and datapath enables.
module fib_ctrl
   import fib_pkg::*;
(
   input  logic clk_i,
   input  logic rst_n,
   input  logic req_vld_i,
   input  logic res_rdy_i,
   input  logic cnt_zero_i,
   output logic load_o,
   output logic step_o,
   output logic req_rdy_o,
   output logic res_vld_o,
   output logic busy_o
);

   fib_state_e state_q;

   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         case (state_q)
            IDLE:    if (req_vld_i)  state_q <= CALC;
            CALC:    if (cnt_zero_i) state_q <= DONE;
            DONE:    if (res_rdy_i)  state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Handshake flags decode the registered state only.
   assign req_rdy_o = (state_q == IDLE);
   assign res_vld_o = (state_q == DONE);
   assign busy_o    = (state_q != IDLE);
   assign load_o    = req_rdy_o && req_vld_i;
   assign step_o    = (state_q == CALC) && !cnt_zero_i;

endmodule

// File: rtl/fib_acc.sv
// Iterative Fibonacci accelerator with valid/ready channels and overflow flag.
// Define FIB_SAT_EN to saturate fib_out to all-ones when F(n) overflows.
module fib_acc
   import fib_pkg::*;
#(
   parameter int unsigned N_W    = FIB_N_W,
   parameter int unsigned DATA_W = FIB_DATA_W
) (
   input  logic              CLK,
   input  logic              rst_n,
   input  logic              vld_in,
   input  logic [N_W-1:0]    n_in,
   output logic              rdy_in,
   output logic              vld_out,
   output logic [DATA_W-1:0] fib_out,
   output logic              ovf_out,
   input  logic              rdy_out,
   output logic              busy
);

   logic              load, step, cnt_zero;
   logic [N_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
   logic              ovf_a_q, ovf_a_d, ovf_b_q, ovf_b_d;
   logic [DATA_W:0]   sum;

   fib_ctrl u_ctrl (
      .clk_i      (CLK),
      .rst_n      (rst_n),
      .req_vld_i  (vld_in),
      .res_rdy_i  (rdy_out),
      .cnt_zero_i (cnt_zero),
      .load_o     (load),
      .step_o     (step),
      .req_rdy_o  (rdy_in),
      .res_vld_o  (vld_out),
      .busy_o     (busy)
   );

   assign cnt_zero = (cnt_q == '0);
   assign sum      = {1'b0, a_q} + {1'b0, b_q};

   always_comb begin
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      ovf_a_d = ovf_a_q;
      ovf_b_d = ovf_b_q;
      if (load) begin
         cnt_d   = n_in;
         a_d     = '0;
         b_d     = {{(DATA_W-1){1'b0}}, 1'b1};
         ovf_a_d = 1'b0;
         ovf_b_d = 1'b0;
      end else if (step) begin
         a_d     = b_q;
         b_d     = sum[DATA_W-1:0];
         // Overflow is sticky and shifts along with the value it belongs to.
         ovf_a_d = ovf_b_q;
         ovf_b_d = ovf_b_q | ovf_a_q | sum[DATA_W];
         cnt_d   = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         ovf_a_q <= 1'b0;
         ovf_b_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         ovf_a_q <= ovf_a_d;
         ovf_b_q <= ovf_b_d;
      end
   end

   assign ovf_out = ovf_a_q;

`ifdef FIB_SAT_EN
   assign fib_out = ovf_a_q ? '1 : a_q;
`else
   assign fib_out = a_q;
`endif

endmodule

// File: tb/tb_fib_acc.sv
// Scoreboard bench for fib_acc: directed requests, decoupled result monitor.
module tb_fib_acc;

   logic        CLK     = 1'b0;
   logic        rst_n   = 1'b0;
   logic        vld_in  = 1'b0;
   logic [7:0]  n_in    = '0;
   logic        rdy_out = 1'b1;
   logic        rdy_in, vld_out, ovf_out, busy;
   logic [31:0] fib_out;

   fib_acc #(
      .N_W    (8),
      .DATA_W (32)
   ) dut (
      .CLK     (CLK),
      .rst_n   (rst_n),
      .vld_in  (vld_in),
      .n_in    (n_in),
      .rdy_in  (rdy_in),
      .vld_out (vld_out),
      .fib_out (fib_out),
      .ovf_out (ovf_out),
      .rdy_out (rdy_out),
      .busy    (busy)
   );

   always #5 CLK = ~CLK;

`ifdef FIB_SAT_EN
   localparam logic [31:0] F48 = 32'hFFFF_FFFF;
`else
   localparam logic [31:0] F48 = 32'd512559680;
`endif

   typedef struct {
      int          n;
      logic [31:0] f;
      logic        o;
      int          acc;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_chk = 0, n_fail = 0, cyc = 0, last_acc = 0, first_acc = 0, rise = 0;
   logic        prev_vld = 1'b0, prev_rdy = 1'b0;
   logic [31:0] held = '0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Monitor: sample at negedge; a handshake happens on the following posedge.
   always @(negedge CLK) begin
      if (!rst_n) begin
         prev_vld = 1'b0;
         prev_rdy = 1'b0;
      end else begin
         if (vld_out) begin
            if (!prev_vld) rise = cyc;
            else if (!prev_rdy) chk("hold_fib_out", 64'(fib_out), 64'(held));
            chk("rdy_in_low_in_done", 64'(rdy_in), 64'd0);
            if (rdy_out) begin
               if (sb.size() == 0) begin
                  chk("unexpected_result", 64'd1, 64'd0);
               end else begin
                  e = sb.pop_front();
                  chk($sformatf("fib_out n=%0d", e.n), 64'(fib_out), 64'(e.f));
                  chk($sformatf("ovf_out n=%0d", e.n), 64'(ovf_out), 64'(e.o));
                  chk($sformatf("latency n=%0d", e.n), 64'(rise - e.acc + 1), 64'(e.n + 2));
               end
            end
         end
         prev_vld = vld_out;
         prev_rdy = rdy_out;
         held     = fib_out;
      end
   end

   // All stimulus tasks start and end 1 time unit after a rising edge.
   task automatic send(input int n, input logic [31:0] f, input logic o, input bit keep);
      int b = 0;
      vld_in = 1'b1;
      n_in   = 8'(n);
      @(negedge CLK);
      while (!rdy_in && b < 3000) begin
         @(negedge CLK);
         b++;
      end
      if (!rdy_in) begin
         n_chk++;
         n_fail++;
         $display("FAIL accept_timeout n=%0d: rdy_in=0, required 1", n);
         @(posedge CLK);
         #1 vld_in = 1'b0;
      end else begin
         sb.push_back('{n, f, o, cyc + 1});
         last_acc = cyc + 1;
         @(posedge CLK);
         #1 if (!keep) vld_in = 1'b0;
      end
   endtask

   task automatic drain();
      int b = 0;
      while (sb.size() != 0 && b < 3000) begin
         @(posedge CLK);
         #1 b++;
      end
      if (sb.size() != 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL result_timeout: %0d results pending, required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, " rdy_in"},  64'(rdy_in),  64'd1);
      chk({tag, " vld_out"}, 64'(vld_out), 64'd0);
      chk({tag, " fib_out"}, 64'(fib_out), 64'd0);
      chk({tag, " ovf_out"}, 64'(ovf_out), 64'd0);
      chk({tag, " busy"},    64'(busy),    64'd0);
   endtask

   initial begin
      int b;
      repeat (2) @(posedge CLK);
      #1 reset_checks("por");
      rst_n = 1'b1;

      send(0, 32'd0, 1'b0, 1'b0);           drain();
      send(1, 32'd1, 1'b0, 1'b0);           drain();
      send(2, 32'd1, 1'b0, 1'b0);           drain();
      send(10, 32'd55, 1'b0, 1'b0);         drain();
      send(12, 32'd144, 1'b0, 1'b0);        drain();
      send(47, 32'd2971215073, 1'b0, 1'b0); drain();
      send(48, F48, 1'b1, 1'b0);            drain();

      // vld_in held high across two requests: one accept per n+3 cycles.
      send(3, 32'd2, 1'b0, 1'b1);
      first_acc = last_acc;
      send(3, 32'd2, 1'b0, 1'b0);
      chk("b2b_accept_spacing", 64'(last_acc - first_acc), 64'd6);
      drain();

      // Backpressure: result must hold while rdy_out stays low.
      rdy_out = 1'b0;
      send(20, 32'd6765, 1'b0, 1'b0);
      b = 0;
      while (!vld_out && b < 100) begin
         @(posedge CLK);
         #1 b++;
      end
      chk("bp_vld_out_rise", 64'(vld_out), 64'd1);
      repeat (5) begin
         @(posedge CLK);
         #1;
      end
      chk("bp_fib_out_held", 64'(fib_out), 64'd6765);
      rdy_out = 1'b1;
      drain();
      chk("rdy_in_after_handshake", 64'(rdy_in), 64'd1);

      // Reset mid-CALC drops the request without emitting a result.
      send(100, 32'd0, 1'b0, 1'b0);
      repeat (20) begin
         @(posedge CLK);
         #1;
      end
      chk("busy_mid_calc", 64'(busy), 64'd1);
      rst_n = 1'b0;
      @(posedge CLK);
      #1 rst_n = 1'b1;
      sb.delete();
      reset_checks("mid_reset");
      send(5, 32'd5, 1'b0, 1'b0);           drain();

      repeat (10) @(posedge CLK);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
